// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU control codes, opcode/funct
// encodings and the skid-buffer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef logic [1:0] buf_state_t;
  localparam buf_state_t ST_EMPTY = 2'd0;
  localparam buf_state_t ST_ONE   = 2'd1;
  localparam buf_state_t ST_TWO   = 2'd2;

  typedef enum logic [1:0] {BSEL_RT, BSEL_SEXT, BSEL_ZEXT} bsel_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct decode into ALU control and second-operand select.
// ALU_ISSUE_IMM_EN adds addi/addiu/slti/andi/ori; otherwise they decode illegal.
module alu_decode import alu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm16,
  input  logic [DATA_W-1:0] rt_data,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] b,
  output logic              illegal
);

  logic [3:0] ctrl_s;
  bsel_e      bsel_s;
  logic [DATA_W-1:0] sext_s;
  logic [DATA_W-1:0] zext_s;

  assign sext_s = {{(DATA_W-16){imm16[15]}}, imm16};
  assign zext_s = {{(DATA_W-16){1'b0}}, imm16};

  // Opcode/funct table lookup
  always_comb begin
    ctrl_s = ALU_ILLEGAL;
    bsel_s = BSEL_RT;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: ctrl_s = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl_s = ALU_SUB;
          FN_AND:          ctrl_s = ALU_AND;
          FN_OR:           ctrl_s = ALU_OR;
          FN_NOR:          ctrl_s = ALU_NOR;
          FN_SLT:          ctrl_s = ALU_SLT;
          default:         ctrl_s = ALU_ILLEGAL;
        endcase
      end
      OP_LW, OP_SW: begin
        ctrl_s = ALU_ADD;
        bsel_s = BSEL_SEXT;
      end
      OP_BEQ, OP_BNE: ctrl_s = ALU_SUB;
`ifdef ALU_ISSUE_IMM_EN
      OP_ADDI, OP_ADDIU: begin
        ctrl_s = ALU_ADD;
        bsel_s = BSEL_SEXT;
      end
      OP_SLTI: begin
        ctrl_s = ALU_SLT;
        bsel_s = BSEL_SEXT;
      end
      OP_ANDI: begin
        ctrl_s = ALU_AND;
        bsel_s = BSEL_ZEXT;
      end
      OP_ORI: begin
        ctrl_s = ALU_OR;
        bsel_s = BSEL_ZEXT;
      end
`endif
      default: ctrl_s = ALU_ILLEGAL;
    endcase
  end

  // Second-operand mux
  always_comb begin
    b = rt_data;
    case (bsel_s)
      BSEL_SEXT: b = sext_s;
      BSEL_ZEXT: b = zext_s;
      default:   b = rt_data;
    endcase
  end

  assign alu_control = ctrl_s;
  assign illegal     = (ctrl_s == ALU_ILLEGAL);

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-stage issue buffer: decodes ID fields and holds them in a 2-entry
// skid buffer with registered in_ready. Optional feature macro: ALU_ISSUE_IMM_EN.
module alu_issue_stage import alu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm16,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic              illegal
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        ctrl;
    logic              ill;
  } entry_t;

  logic [3:0]        dec_ctrl_s;
  logic [DATA_W-1:0] dec_b_s;
  logic              dec_ill_s;
  entry_t            new_s;
  entry_t            head_r, tail_r;
  entry_t            head_nxt_s, tail_nxt_s;
  buf_state_t        state_r, state_nxt_s;
  logic              in_ready_r, out_valid_r;
  logic              accept_s, pop_s;

  alu_decode #(.DATA_W(DATA_W)) u_decode (
    .opcode      (opcode),
    .funct       (funct),
    .imm16       (imm16),
    .rt_data     (rt_data),
    .alu_control (dec_ctrl_s),
    .b           (dec_b_s),
    .illegal     (dec_ill_s)
  );

  assign new_s    = '{a: rs_data, b: dec_b_s, ctrl: dec_ctrl_s, ill: dec_ill_s};
  assign accept_s = in_valid & in_ready_r;
  assign pop_s    = out_valid_r & out_ready;

  // Next state and entry movement; flush overrides any accept or pop
  always_comb begin
    state_nxt_s = state_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            head_nxt_s  = new_s;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            state_nxt_s = ST_ONE;
            head_nxt_s  = new_s;
          end else if (accept_s) begin
            state_nxt_s = ST_TWO;
            tail_nxt_s  = new_s;
          end else if (pop_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_nxt_s = ST_ONE;
            head_nxt_s  = tail_r;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // Buffer registers; handshake flags are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      head_r      <= '0;
      tail_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign alu_a       = head_r.a;
  assign alu_b       = head_r.b;
  assign alu_control = head_r.ctrl;
  assign illegal     = head_r.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases then randomized traffic
// checked against an instruction-level reference model and FIFO queue.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data, alu_a, alu_b;
  logic [15:0] imm16;
  logic [3:0]  alu_control;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  bit   ready_exp = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  // Reference: what the ALU should be told for one instruction
  function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] imm);
    exp_t e;
    logic [31:0] sx, zx;
    zx = {16'h0000, imm};
    sx = imm[15] ? zx - 32'h0001_0000 : zx;
    e.a = rs; e.b = rt; e.ctrl = 4'b1111;
    if (opc == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) e.ctrl = 4'b0010;
      else if (fn == 6'h22 || fn == 6'h23) e.ctrl = 4'b0110;
      else if (fn == 6'h24) e.ctrl = 4'b0000;
      else if (fn == 6'h25) e.ctrl = 4'b0001;
      else if (fn == 6'h27) e.ctrl = 4'b1100;
      else if (fn == 6'h2A) e.ctrl = 4'b0111;
    end else if (opc == 6'h23 || opc == 6'h2B) begin
      e.ctrl = 4'b0010; e.b = sx;
    end else if (opc == 6'h04 || opc == 6'h05) begin
      e.ctrl = 4'b0110;
    end
`ifdef ALU_ISSUE_IMM_EN
    else if (opc == 6'h08 || opc == 6'h09) begin e.ctrl = 4'b0010; e.b = sx; end
    else if (opc == 6'h0A) begin e.ctrl = 4'b0111; e.b = sx; end
    else if (opc == 6'h0C) begin e.ctrl = 4'b0000; e.b = zx; end
    else if (opc == 6'h0D) begin e.ctrl = 4'b0001; e.b = zx; end
`endif
    e.ill = (e.ctrl == 4'b1111);
    return e;
  endfunction

  // Monitor: compare head against the scoreboard, then retire popped/flushed entries
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      ready_exp = (q.size() < 2);
      if (q.size() != 0 && out_valid) begin
        chk("alu_a", alu_a, q[0].a);
        chk("alu_control", {28'd0, alu_control}, {28'd0, q[0].ctrl});
        chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
        if (!q[0].ill) chk("alu_b", alu_b, q[0].b);
      end
      if (flush) q.delete();
      else if (q.size() != 0 && out_ready) void'(q.pop_front());
    end
  end

  // One clock of stimulus; accepted instructions are pushed at the active edge
  task automatic cycle(input bit v, input bit ordy, input bit fl,
                       input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, output bit taken);
    in_valid = v; out_ready = ordy; flush = fl;
    opcode = opc; funct = fn; rs_data = rs; rt_data = rt; imm16 = imm;
    @(posedge clk);
    taken = v && ready_exp && !fl;
    if (taken) q.push_back(model(opc, fn, rs, rt, imm));
    #1;
  endtask

  task automatic idle(input bit ordy);
    bit t;
    cycle(1'b0, ordy, 1'b0, 6'h00, 6'h00, 32'd0, 32'd0, 16'h0000, t);
  endtask

  logic [5:0] opc_tab [12];
  logic [5:0] fn_tab [10];

  initial begin
    bit t;
    opc_tab = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D};
    fn_tab  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F, 6'h26};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    opcode = '0; funct = '0; rs_data = '0; rt_data = '0; imm16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // sub, lw, ori, illegal funct, then legal add back to back
    cycle(1'b1, 1'b1, 1'b0, 6'h00, 6'h22, 32'd10, 32'd3, 16'h0000, t);
    chk("sub_ctrl", {28'd0, alu_control}, 32'h6);
    chk("sub_a", alu_a, 32'd10);
    chk("sub_b", alu_b, 32'd3);
    chk("sub_ill", {31'd0, illegal}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 6'h23, 6'h00, 32'd100, 32'd7, 16'hFFFC, t);
    chk("lw_ctrl", {28'd0, alu_control}, 32'h2);
    chk("lw_b", alu_b, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 6'h0D, 6'h00, 32'd5, 32'd7, 16'hFFFC, t);
`ifdef ALU_ISSUE_IMM_EN
    chk("ori_ctrl", {28'd0, alu_control}, 32'h1);
    chk("ori_b", alu_b, 32'h0000_FFFC);
`else
    chk("ori_ctrl", {28'd0, alu_control}, 32'hF);
    chk("ori_ill", {31'd0, illegal}, 32'd1);
`endif
    cycle(1'b1, 1'b1, 1'b0, 6'h00, 6'h3F, 32'd1, 32'd2, 16'h0000, t);
    chk("bad_fn_ctrl", {28'd0, alu_control}, 32'hF);
    chk("bad_fn_ill", {31'd0, illegal}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 6'h00, 6'h20, 32'd4, 32'd5, 16'h0000, t);
    chk("after_ill_valid", {31'd0, out_valid}, 32'd1);
    chk("after_ill_ctrl", {28'd0, alu_control}, 32'h2);
    idle(1'b1);

    // Backpressure: three offers, only two fit
    cycle(1'b1, 1'b0, 1'b0, 6'h00, 6'h24, 32'd11, 32'd12, 16'h0000, t);
    cycle(1'b1, 1'b0, 1'b0, 6'h00, 6'h25, 32'd21, 32'd22, 16'h0000, t);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head_a", alu_a, 32'd11);
    t = 1'b0;
    for (int i = 0; i < 10 && !t; i++)
      cycle(1'b1, (i != 0), 1'b0, 6'h00, 6'h27, 32'd31, 32'd32, 16'h0000, t);
    chk("bp_third_taken", {31'd0, t}, 32'd1);
    repeat (3) idle(1'b1);

    // Flush in TWO while offering
    cycle(1'b1, 1'b0, 1'b0, 6'h04, 6'h00, 32'd41, 32'd42, 16'h0000, t);
    cycle(1'b1, 1'b0, 1'b0, 6'h05, 6'h00, 32'd51, 32'd52, 16'h0000, t);
    chk("pre_flush_ready", {31'd0, in_ready}, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 6'h00, 6'h2A, 32'd61, 32'd62, 16'h0000, t);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) idle(1'b1);

    // Asynchronous reset with an entry buffered
    cycle(1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, 32'd71, 32'd72, 16'h8000, t);
    in_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opc_tab[$urandom_range(0, 11)];
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 9)];
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 31) == 0, o, f, $urandom, $urandom, 16'($urandom), t);
    end
    repeat (4) idle(1'b1);
    chk("drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
